// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin mover from 4 FWFT input FIFOs
// to 4 output FIFOs, one word per cycle, honouring almost-full.
//
// Ports:
//   clk, reset_L     clock, synchronous active-low reset
//   enable           scheduling allowed (control FSM ACTIVE)
//   in_empty[4]      input FIFO empty flags
//   in_data[4*W]     FWFT head words, ch i at [i*W +: W]
//   out_almost_full  output FIFO almost-full flags
//   in_pop[4]        one-hot pop, combinational
//   out_push[4]      one-hot push, registered
//   out_data[W]      word for out_push, registered
//   sched_state[3]   one-hot IDLE/RUN/STALL
//   stall_count      saturating count of STALL cycles
module fifo_rr_scheduler #(
   parameter int WIDTH = 6,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset_L,
   input  logic               enable,
   input  logic [3:0]         in_empty,
   input  logic [4*WIDTH-1:0] in_data,
   input  logic [3:0]         out_almost_full,
   output logic [3:0]         in_pop,
   output logic [3:0]         out_push,
   output logic [WIDTH-1:0]   out_data,
   output logic [2:0]         sched_state,
   output logic [CNT_W-1:0]   stall_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_RUN   = 3'b010,
      S_STALL = 3'b100
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       rr_q, rr_d;
   logic [3:0]       push_q, push_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0] dest [4];
   logic [3:0] elig;
   logic       gnt_vld;
   logic [1:0] gnt;
   logic [1:0] idx;
   logic       idle_c;

   // Eligibility is gated by reset so no pop leaks out during reset.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dest[i] = in_data[i*WIDTH+WIDTH-2 +: 2];
         elig[i] = reset_L & enable & ~in_empty[i]
                 & ~out_almost_full[dest[i]];
      end
   end

   // Scan from the channel after the last winner; 2-bit wrap.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = rr_q;
      idx     = rr_q;
      for (int k = 1; k <= 4; k++) begin
         idx = rr_q + 2'(k);
         if (!gnt_vld && elig[idx]) begin
            gnt_vld = 1'b1;
            gnt     = idx;
         end
      end
   end

   assign in_pop = gnt_vld ? (4'b0001 << gnt) : 4'b0000;

   always_comb begin
      push_d = 4'b0000;
      data_d = data_q;
      rr_d   = rr_q;
      if (gnt_vld) begin
         push_d = 4'b0001 << dest[gnt];
         data_d = in_data[gnt*WIDTH +: WIDTH];
         rr_d   = gnt;
      end
   end

   assign idle_c = ~enable | (&in_empty);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (idle_c) begin
         state_d = S_IDLE;
      end else if (gnt_vld) begin
         state_d = S_RUN;
      end else begin
         state_d = S_STALL;
      end
      if (state_d == S_STALL && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q <= S_IDLE;
         rr_q    <= 2'd3;
         push_q  <= 4'b0000;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         push_q  <= push_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_push    = push_q;
   assign out_data    = data_q;
   assign sched_state = state_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed tests with a queue-free
// behavioural model compared every cycle, plus literal pins.
module tb_fifo_rr_scheduler;

   localparam int W = 6;
   localparam int C = 8;

   logic         clk = 1'b0;
   logic         reset_L = 1'b0;
   logic         enable = 1'b0;
   logic [3:0]   in_empty = 4'b1111;
   logic [4*W-1:0] in_data = '0;
   logic [3:0]   out_almost_full = 4'b0000;
   logic [3:0]   in_pop;
   logic [3:0]   out_push;
   logic [W-1:0] out_data;
   logic [2:0]   sched_state;
   logic [C-1:0] stall_count;

   int n_chk = 0;
   int n_fail = 0;

   fifo_rr_scheduler #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk),
      .reset_L(reset_L),
      .enable(enable),
      .in_empty(in_empty),
      .in_data(in_data),
      .out_almost_full(out_almost_full),
      .in_pop(in_pop),
      .out_push(out_push),
      .out_data(out_data),
      .sched_state(sched_state),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Model state, held as plain integers.
   int         m_rr = 3;
   logic [3:0] m_push = 4'b0000;
   logic [W-1:0] m_data = '0;
   logic [2:0] m_state = 3'b001;
   int         m_cnt = 0;

   function automatic int dst_of(logic [4*W-1:0] d, int c);
      logic [W-1:0] w;
      w = d[c*W +: W];
      return int'(w[W-1:W-2]);
   endfunction

   function automatic int grant_of(int rr, logic en,
                                   logic [3:0] emp,
                                   logic [3:0] af,
                                   logic [4*W-1:0] d);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (rr + k) % 4;
         if (en && !emp[c] && !af[dst_of(d, c)]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_pop();
      int g;
      g = grant_of(m_rr, enable, in_empty, out_almost_full, in_data);
      if (!reset_L || g < 0) return 4'b0000;
      return 4'(1 << g);
   endfunction

   always @(posedge clk) begin
      int g;
      if (!reset_L) begin
         m_rr    <= 3;
         m_push  <= 4'b0000;
         m_data  <= '0;
         m_state <= 3'b001;
         m_cnt   <= 0;
      end else begin
         g = grant_of(m_rr, enable, in_empty,
                      out_almost_full, in_data);
         if (!enable || in_empty == 4'b1111) begin
            m_state <= 3'b001;
         end else if (g >= 0) begin
            m_state <= 3'b010;
         end else begin
            m_state <= 3'b100;
            if (m_cnt < 255) m_cnt <= m_cnt + 1;
         end
         if (g >= 0) begin
            m_push <= 4'(1 << dst_of(in_data, g));
            m_data <= in_data[g*W +: W];
            m_rr   <= g;
         end else begin
            m_push <= 4'b0000;
         end
      end
   end

   task automatic check(string nm, logic [31:0] act,
                        logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("in_pop", 32'(in_pop), 32'(exp_pop()));
      check("out_push", 32'(out_push), 32'(m_push));
      check("out_data", 32'(out_data), 32'(m_data));
      check("state", 32'(sched_state), 32'(m_state));
      check("stall_cnt", 32'(stall_count), 32'(m_cnt));
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic logic [W-1:0] wd(int dst, int lo);
      return {2'(dst), 4'(lo)};
   endfunction

   task automatic do_reset();
      reset_L = 1'b0;
      step(1);
      reset_L = 1'b1;
   endtask

   initial begin
      // 1: reset with random inputs
      reset_L = 1'b0;
      repeat (2) begin
         enable = 1'($urandom);
         in_empty = 4'($urandom);
         in_data = 24'($urandom);
         out_almost_full = 4'($urandom);
         step(1);
      end
      #1;
      check("rst_pop", 32'(in_pop), 32'h0);
      check("rst_push", 32'(out_push), 32'h0);
      check("rst_state", 32'(sched_state), 32'h1);
      check("rst_cnt", 32'(stall_count), 32'h0);

      // 2: all four non-empty, dest = i
      reset_L = 1'b1;
      enable = 1'b1;
      in_empty = 4'b0000;
      out_almost_full = 4'b0000;
      in_data = {wd(3, 4), wd(2, 3), wd(1, 2), wd(0, 1)};
      #1;
      check("rr_pop0", 32'(in_pop), 32'h1);
      step(1);
      #1;
      check("rr_pop1", 32'(in_pop), 32'h2);
      check("rr_push0", 32'(out_push), 32'h1);
      check("rr_data0", 32'(out_data), 32'h01);
      step(1);
      #1;
      check("rr_pop2", 32'(in_pop), 32'h4);
      check("rr_push1", 32'(out_push), 32'h2);
      check("rr_data1", 32'(out_data), 32'h12);
      step(6);

      // 3: ch2 blocked on almost-full of dest 1
      do_reset();
      enable = 1'b1;
      in_empty = 4'b1011;
      in_data = {wd(0, 0), wd(1, 10), wd(0, 0), wd(0, 0)};
      out_almost_full = 4'b0010;
      step(5);
      check("stall_cnt5", 32'(stall_count), 32'd5);
      check("stall_st", 32'(sched_state), 32'h4);
      check("stall_pop", 32'(in_pop), 32'h0);
      out_almost_full = 4'b0000;
      #1;
      check("unblk_pop", 32'(in_pop), 32'h4);
      step(1);
      check("unblk_push", 32'(out_push), 32'h2);
      check("unblk_data", 32'(out_data), 32'h1a);
      check("unblk_st", 32'(sched_state), 32'h2);
      in_empty = 4'b1111;
      step(1);

      // 4: blocked ch0 skipped, turn order kept
      do_reset();
      enable = 1'b1;
      in_empty = 4'b1100;
      in_data = {wd(0, 0), wd(0, 5), wd(3, 7), wd(2, 6)};
      out_almost_full = 4'b0100;
      #1;
      check("skip_pop", 32'(in_pop), 32'h2);
      step(1);
      out_almost_full = 4'b0000;
      in_empty = 4'b1010;
      #1;
      check("after1_ch2", 32'(in_pop), 32'h4);
      step(1);
      in_empty = 4'b1110;
      #1;
      check("wrap_ch0", 32'(in_pop), 32'h1);
      step(1);

      // 5: reset while a word is in flight
      do_reset();
      enable = 1'b1;
      in_empty = 4'b0111;
      in_data = {wd(0, 9), wd(0, 0), wd(0, 0), wd(0, 0)};
      #1;
      check("fl_pop", 32'(in_pop), 32'h8);
      step(1);
      reset_L = 1'b0;
      step(1);
      check("fl_drop", 32'(out_push), 32'h0);
      check("fl_state", 32'(sched_state), 32'h1);
      reset_L = 1'b1;
      in_empty = 4'b0000;
      #1;
      check("fl_rr3", 32'(in_pop), 32'h1);

      // 6: enable drop with word in flight, then disabled
      step(1);
      enable = 1'b0;
      #1;
      check("dis_pop", 32'(in_pop), 32'h0);
      check("dis_inflt", 32'(out_push), 32'h1);
      step(3);
      check("dis_state", 32'(sched_state), 32'h1);
      check("dis_push", 32'(out_push), 32'h0);

      // 6b: long stall saturates the counter
      do_reset();
      enable = 1'b1;
      in_empty = 4'b1110;
      in_data = {wd(0, 0), wd(0, 0), wd(0, 0), wd(0, 3)};
      out_almost_full = 4'b0001;
      step(300);
      check("sat_cnt", 32'(stall_count), 32'd255);
      check("sat_state", 32'(sched_state), 32'h4);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
